vec_argmax_ctrl: RTL and testbench

//  Sequences the team's floating-point max compare unit over a streamed vector; returns max value and first index.

---
 rtl/argmax_pkg.sv | 34 +++
 rtl/vec_argmax_ctrl_max.sv | 60 ++++++
 rtl/vec_argmax_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_vec_argmax_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared types and float helpers for the argmax controller.
// Holds FSM states, per-format field widths and canonical qNaNs.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WAIT,
    DONE
  } state_t;

  localparam int CMP_LAT = 1;

  localparam int EXP_W_HALF   = 5;
  localparam int MAN_W_HALF   = 10;
  localparam int EXP_W_SINGLE = 8;
  localparam int MAN_W_SINGLE = 23;

  localparam logic [15:0] QNAN_HALF   = 16'h7E00;
  localparam logic [31:0] QNAN_SINGLE = 32'h7FC0_0000;

  function automatic logic is_nan(
    input logic [31:0] v,
    input logic        sgl
  );
    if (sgl)
      is_nan = (&v[MAN_W_SINGLE +: EXP_W_SINGLE]) &&
               (|v[MAN_W_SINGLE-1:0]);
    else
      is_nan = (&v[MAN_W_HALF +: EXP_W_HALF]) &&
               (|v[MAN_W_HALF-1:0]);
  endfunction

endpackage

// File: rtl/vec_argmax_ctrl_max.sv
// Float max compare unit: b_max=1 only when b is strictly greater than a.
// NaN b never wins; a NaN a is always replaced. Latency CMP_LAT cycles.
module max
  import argmax_pkg::*;
#(
  parameter int    BITS      = 16,
  parameter string PRECISION = "HALF"
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  output logic            b_max
);

  localparam logic SGL = (PRECISION == "SINGLE");

  // Map sign-magnitude to an unsigned order; both zeros share one key.
  function automatic logic [BITS-1:0] order_key(
    input logic [BITS-1:0] x
  );
    if (x[BITS-2:0] == '0)
      order_key = {1'b1, {(BITS-1){1'b0}}};
    else if (x[BITS-1])
      order_key = ~x;
    else
      order_key = {1'b1, x[BITS-2:0]};
  endfunction

  logic                w_a_nan;
  logic                w_b_nan;
  logic                w_gt;
  logic [CMP_LAT-1:0]  r_vld;
  logic [CMP_LAT-1:0]  r_gt;

  assign w_a_nan = is_nan(32'(a), SGL);
  assign w_b_nan = is_nan(32'(b), SGL);
  assign w_gt    = !w_b_nan &&
                   (w_a_nan || (order_key(b) > order_key(a)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= '0;
      r_gt  <= '0;
    end else begin
      r_vld[0] <= in_valid;
      r_gt[0]  <= w_gt;
      for (int i = 1; i < CMP_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_gt[i]  <= r_gt[i-1];
      end
    end
  end

  assign out_valid = r_vld[CMP_LAT-1];
  assign b_max     = r_gt[CMP_LAT-1];

endmodule

// File: rtl/vec_argmax_ctrl.sv
// Streams a vector through the max compare unit; returns max and first index.
// Optional ARGMAX_NAN_SKIP_EN: NaN elements are counted but never selected.
module vec_argmax_ctrl
  import argmax_pkg::*;
#(
  parameter int    BITS      = 16,
  parameter string PRECISION = "HALF",
  parameter int    MAX_LEN   = 1024,
  localparam int   IDXW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BITS-1:0] s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [BITS-1:0] m_data,
  output logic [IDXW-1:0] m_index,
  output logic            m_overflow
);

  localparam int            CW       = IDXW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);
  localparam logic          ONE_ELEM = (MAX_LEN == 1);

  state_t          r_state;
  state_t          w_next;
  logic [BITS-1:0] r_best;
  logic [BITS-1:0] r_elem;
  logic [IDXW-1:0] r_best_idx;
  logic [IDXW-1:0] r_idx;
  logic [CW-1:0]   r_count;
  logic            r_last;
  logic            r_ovf;
  logic            w_xfer;
  logic            w_cnt_end;
  logic            w_cmp_valid;
  logic            w_cmp_done;
  logic            w_cmp_bmax;
  logic            w_skip;

`ifdef ARGMAX_NAN_SKIP_EN
  localparam logic SGL = (PRECISION == "SINGLE");
  localparam logic [BITS-1:0] QNAN =
    SGL ? BITS'(QNAN_SINGLE) : BITS'(QNAN_HALF);

  logic r_best_vld;
  logic w_nan;

  assign w_nan  = is_nan(32'(s_data), SGL);
  assign w_skip = w_nan || !r_best_vld;
`else
  assign w_skip = 1'b0;
`endif

  assign s_ready   = rstn &&
                     ((r_state == IDLE) || (r_state == ACCUM));
  assign w_xfer    = s_valid && s_ready;
  assign w_cnt_end = (r_count == LAST_CNT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cmp_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_xfer)
          w_next = (s_last || ONE_ELEM) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (w_xfer) begin
          if (w_skip) begin
            w_next = (s_last || w_cnt_end) ? DONE : ACCUM;
          end else begin
            w_cmp_valid = 1'b1;
            w_next      = WAIT;
          end
        end
      end
      WAIT: begin
        if (w_cmp_done)
          w_next = (r_last || w_cnt_end) ? DONE : ACCUM;
      end
      DONE: begin
        if (m_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_best     <= '0;
      r_best_idx <= '0;
      r_elem     <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_last     <= 1'b0;
      r_ovf      <= 1'b0;
`ifdef ARGMAX_NAN_SKIP_EN
      r_best_vld <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_best     <= s_data;
            r_best_idx <= '0;
            r_count    <= CW'(1);
            r_ovf      <= ONE_ELEM && !s_last;
`ifdef ARGMAX_NAN_SKIP_EN
            r_best_vld <= !w_nan;
            if (w_nan) r_best <= QNAN;
`endif
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            if (w_skip) begin
              r_count <= r_count + CW'(1);
              r_ovf   <= w_cnt_end && !s_last;
`ifdef ARGMAX_NAN_SKIP_EN
              // First real value after leading NaNs loads directly.
              if (!w_nan) begin
                r_best     <= s_data;
                r_best_idx <= r_count[IDXW-1:0];
                r_best_vld <= 1'b1;
              end
`endif
            end else begin
              r_elem <= s_data;
              r_idx  <= r_count[IDXW-1:0];
              r_last <= s_last;
            end
          end
        end
        WAIT: begin
          if (w_cmp_done) begin
            if (w_cmp_bmax) begin
              r_best     <= r_elem;
              r_best_idx <= r_idx;
            end
            r_count <= r_count + CW'(1);
            r_ovf   <= w_cnt_end && !r_last;
          end
        end
        DONE: begin
          if (m_ready) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  max #(
    .BITS      (BITS),
    .PRECISION (PRECISION)
  ) u_max (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (w_cmp_valid),
    .a         (r_best),
    .b         (s_data),
    .out_valid (w_cmp_done),
    .b_max     (w_cmp_bmax)
  );

  assign m_valid    = (r_state == DONE);
  assign m_data     = r_best;
  assign m_index    = r_best_idx;
  assign m_overflow = r_ovf;

endmodule

// File: tb/tb_vec_argmax_ctrl.sv
// Self-checking bench for vec_argmax_ctrl (HALF, MAX_LEN=4).
// Directed scenarios plus random vectors against a real-valued model.
module tb_vec_argmax_ctrl;

  localparam int BITS    = 16;
  localparam int MAX_LEN = 4;
  localparam int IDXW    = 2;

  logic            clk    = 1'b0;
  logic            rstn   = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [BITS-1:0] s_data = '0;
  logic            s_last = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [BITS-1:0] m_data;
  logic [IDXW-1:0] m_index;
  logic            m_overflow;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0]     st_d[$];
  bit              st_l[$];
  logic [15:0]     rs_d[$];
  logic [IDXW-1:0] rs_i[$];
  bit              rs_o[$];
  logic [15:0]     ex_d[$];
  logic [IDXW-1:0] ex_i[$];
  bit              ex_o[$];

  vec_argmax_ctrl #(
    .BITS      (BITS),
    .PRECISION ("HALF"),
    .MAX_LEN   (MAX_LEN)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_index    (m_index),
    .m_overflow (m_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic real h2r(input logic [15:0] h);
    real mag;
    int  e;
    int  m;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31)     mag = 1.0e30;
    else if (e == 0) mag = real'(m) * (2.0 ** (-24.0));
    else             mag = real'(1024 + m) * (2.0 ** real'(e - 25));
    return h[15] ? -mag : mag;
  endfunction

  // Reference: split stream into vectors, first strict max wins.
  function automatic void model();
    real         best;
    int          bidx;
    int          n;
    logic [15:0] bd;
    ex_d.delete(); ex_i.delete(); ex_o.delete();
    n = 0; best = 0.0; bidx = 0; bd = '0;
    foreach (st_d[j]) begin
      if (n == 0) begin
        best = h2r(st_d[j]); bd = st_d[j]; bidx = 0;
      end else if (h2r(st_d[j]) > best) begin
        best = h2r(st_d[j]); bd = st_d[j]; bidx = n;
      end
      n++;
      if (st_l[j] || n == MAX_LEN) begin
        ex_d.push_back(bd);
        ex_i.push_back(2'(bidx));
        ex_o.push_back(!st_l[j] && n == MAX_LEN);
        n = 0;
      end
    end
  endfunction

  function automatic logic [15:0] rnd_half();
    logic [4:0] e;
    logic [9:0] m;
    case ($urandom_range(0, 6))
      0: e = 5'd0;  1: e = 5'd1;  2: e = 5'd14; 3: e = 5'd15;
      4: e = 5'd16; 5: e = 5'd17; default: e = 5'd30;
    endcase
    case ($urandom_range(0, 3))
      0: m = 10'h000; 1: m = 10'h001;
      2: m = 10'h200; default: m = 10'h3FF;
    endcase
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  task automatic push(input logic [15:0] d, input bit l);
    int n = 0;
    @(negedge clk);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && n < 200) begin
      @(negedge clk); n++;
    end
    n_chk++;
    if (!s_ready)
      $display("FAIL push_accept: s_ready=%0b required 1 (data %h)",
               s_ready, d);
    else n_pass++;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic take(input int dly);
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 200) begin
      @(negedge clk); n++;
    end
    n_chk++;
    if (!m_valid) begin
      $display("FAIL take_valid: m_valid=%0b required 1", m_valid);
      return;
    end
    n_pass++;
    repeat (dly) @(negedge clk);
    rs_d.push_back(m_data);
    rs_i.push_back(m_index);
    rs_o.push_back(m_overflow);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic run_stream(input int nres);
    rs_d.delete(); rs_i.delete(); rs_o.delete();
    fork
      begin
        foreach (st_d[j]) push(st_d[j], st_l[j]);
      end
      begin
        for (int k = 0; k < nres; k++) take($urandom_range(0, 3));
      end
    join
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (s_ready !== 1'b0)
      $display("FAIL rst_s_ready: got %b required 0", s_ready);
    else n_pass++;
    n_chk++;
    if (m_valid !== 1'b0)
      $display("FAIL rst_m_valid: got %b required 0", m_valid);
    else n_pass++;
    n_chk++;
    if (m_data !== 16'h0)
      $display("FAIL rst_m_data: got %h required 0000", m_data);
    else n_pass++;
    n_chk++;
    if (m_index !== 2'd0)
      $display("FAIL rst_m_index: got %0d required 0", m_index);
    else n_pass++;
    n_chk++;
    if (m_overflow !== 1'b0)
      $display("FAIL rst_m_overflow: got %b required 0", m_overflow);
    else n_pass++;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if (s_ready !== 1'b1)
      $display("FAIL idle_s_ready: got %b required 1", s_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    st_d = '{16'h3C00, 16'h4000, 16'hC000};
    st_l = '{1'b0, 1'b0, 1'b1};
    run_stream(1);
    n_chk++;
    if (rs_d.size() != 1 || rs_d[0] !== 16'h4000)
      $display("FAIL basic_data: got %h required 4000",
               rs_d.size() ? rs_d[0] : 16'hxxxx);
    else n_pass++;
    n_chk++;
    if (rs_i.size() != 1 || rs_i[0] !== 2'd1)
      $display("FAIL basic_index: got %0d required 1",
               rs_i.size() ? rs_i[0] : 2'd0);
    else n_pass++;
    n_chk++;
    if (rs_o.size() != 1 || rs_o[0] !== 1'b0)
      $display("FAIL basic_ovf: got %0d required 0",
               rs_o.size() ? rs_o[0] : 1'b1);
    else n_pass++;
  endtask

  task automatic test_single_latency();
    push(16'h4200, 1'b1);
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 16'h4200 || m_index !== 2'd0)
      $display("FAIL single: valid=%b data=%h idx=%0d required 1/4200/0",
               m_valid, m_data, m_index);
    else n_pass++;
    rs_d.delete(); rs_i.delete(); rs_o.delete();
    take(0);
    push(16'h3C00, 1'b0);
    push(16'h4000, 1'b1);
    n_chk++;
    if (m_valid !== 1'b0)
      $display("FAIL accum_lat_early: m_valid=%b required 0", m_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (m_valid !== 1'b1 || m_data !== 16'h4000 || m_index !== 2'd1)
      $display("FAIL accum_lat: valid=%b data=%h idx=%0d required 1/4000/1",
               m_valid, m_data, m_index);
    else n_pass++;
    take(0);
  endtask

  task automatic test_ties_hold();
    int n = 0;
    push(16'h4000, 1'b0);
    push(16'hBC00, 1'b0);
    push(16'h4000, 1'b1);
    while (!m_valid && n < 50) begin
      @(negedge clk); n++;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++;
      if ({m_valid, m_data, m_index, s_ready} !==
          {1'b1, 16'h4000, 2'd0, 1'b0})
        $display("FAIL tie_hold c%0d: v=%b d=%h i=%0d rdy=%b required 1/4000/0/0",
                 c, m_valid, m_data, m_index, s_ready);
      else n_pass++;
    end
    rs_d.delete(); rs_i.delete(); rs_o.delete();
    take(0);
  endtask

  task automatic test_overflow();
    st_d = '{16'h3C00, 16'h4400, 16'h4000, 16'h4400, 16'hC000, 16'h3800};
    st_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_stream(2);
    n_chk++;
    if (rs_d.size() != 2)
      $display("FAIL ovf_count: got %0d required 2", rs_d.size());
    else begin
      n_pass++;
      n_chk++;
      if ({rs_d[0], rs_i[0], rs_o[0]} !== {16'h4400, 2'd1, 1'b1})
        $display("FAIL ovf_vec0: got %h/%0d/%0d required 4400/1/1",
                 rs_d[0], rs_i[0], rs_o[0]);
      else n_pass++;
      n_chk++;
      if ({rs_d[1], rs_i[1], rs_o[1]} !== {16'h3800, 2'd1, 1'b0})
        $display("FAIL ovf_vec1: got %h/%0d/%0d required 3800/1/0",
                 rs_d[1], rs_i[1], rs_o[1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_wait();
    push(16'h3C00, 1'b0);
    push(16'h4000, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    n_chk++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL wait_rst: s_ready=%b m_valid=%b required 0/0",
               s_ready, m_valid);
    else n_pass++;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    st_d = '{16'hC000, 16'hBC00};
    st_l = '{1'b0, 1'b1};
    run_stream(1);
    n_chk++;
    if (rs_d.size() != 1 ||
        {rs_d[0], rs_i[0], rs_o[0]} !== {16'hBC00, 2'd1, 1'b0})
      $display("FAIL post_rst: got %h/%0d required BC00/1/0",
               rs_d.size() ? rs_d[0] : 16'hxxxx,
               rs_i.size() ? rs_i[0] : 2'd0);
    else n_pass++;
  endtask

  task automatic test_random();
    int nv;
    for (int it = 0; it < 30; it++) begin
      st_d.delete(); st_l.delete();
      nv = $urandom_range(1, 10);
      for (int j = 0; j < nv; j++) begin
        st_d.push_back(rnd_half());
        st_l.push_back(j == nv - 1 || $urandom_range(0, 2) == 0);
      end
      model();
      run_stream(ex_d.size());
      n_chk++;
      if (rs_d.size() != ex_d.size())
        $display("FAIL rnd_count it%0d: got %0d required %0d",
                 it, rs_d.size(), ex_d.size());
      else begin
        n_pass++;
        foreach (ex_d[k]) begin
          n_chk++;
          if ({rs_d[k], rs_i[k], rs_o[k]} !== {ex_d[k], ex_i[k], ex_o[k]})
            $display("FAIL rnd it%0d v%0d: got %h/%0d/%0d required %h/%0d/%0d",
                     it, k, rs_d[k], rs_i[k], rs_o[k],
                     ex_d[k], ex_i[k], ex_o[k]);
          else n_pass++;
        end
      end
    end
  endtask

`ifdef ARGMAX_NAN_SKIP_EN
  task automatic test_nan_skip();
    st_d = '{16'h7E00, 16'h3C00, 16'h7E01, 16'h7E00, 16'h7E00};
    st_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_stream(2);
    n_chk++;
    if (rs_d.size() != 2)
      $display("FAIL nan_count: got %0d required 2", rs_d.size());
    else begin
      n_pass++;
      n_chk++;
      if ({rs_d[0], rs_i[0]} !== {16'h3C00, 2'd1})
        $display("FAIL nan_mixed: got %h/%0d required 3C00/1",
                 rs_d[0], rs_i[0]);
      else n_pass++;
      n_chk++;
      if ({rs_d[1], rs_i[1]} !== {16'h7E00, 2'd0})
        $display("FAIL nan_all: got %h/%0d required 7E00/0",
                 rs_d[1], rs_i[1]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_single_latency();
    test_ties_hold();
    test_overflow();
    test_reset_in_wait();
`ifdef ARGMAX_NAN_SKIP_EN
    test_nan_skip();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
